node_fetch_responder: RTL
=========================

# node_fetch_responder

Memory-side responder for the tree walker's node-fetch port. It accepts the walker's level-held `dram_req`/`dram_addr` request and returns one 512-bit hash-tree node on `dram_data` with a single-cycle `dram_valid` pulse. A node is fetched as an 8-beat × 64-bit burst from the backing memory read port. A one-line buffer short-circuits repeat fetches of the same line, and a window check returns a null node for out-of-range addresses so the walker terminates cleanly.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: walker and memory byte-address width.
- `BEAT_BITS`, 64: memory read beat width.
- `MEM_BASE`, 32'h0000_1000: lowest valid node address (the tree root).
- `MEM_LIMIT`, 32'h0100_0000: first invalid address, exclusive.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `dram_req` in 1: walker request, held high until `dram_valid` is seen.
- `dram_addr` in ADDR_WIDTH: node byte address; bits [5:0] are ignored (64-byte line).
- `dram_data` out 512: node line, registered and held until the next response.
- `dram_valid` out 1: one-cycle response pulse.
- `buf_flush` in 1: pulse that invalidates the line buffer.
- `mem_rd_req` out 1: burst request, held until `mem_rd_ready`.
- `mem_rd_addr` out ADDR_WIDTH: line-aligned burst address.
- `mem_rd_ready` in 1: burst accepted in this cycle.
- `mem_rd_data` in BEAT_BITS: read beat.
- `mem_rd_valid` in 1: beat valid; beats return in order, 8 per burst.
- `oob_err` out 1: sticky; set on any out-of-range request.
- `stray_err` out 1: sticky; set when `mem_rd_valid` arrives outside COLLECT.
- `hit_count` out 16: saturating count of line-buffer hits.

## Operation
- States: IDLE, ISSUE, COLLECT, RESP, DONE.
- **IDLE:** when `dram_req`=1, compute `line = {dram_addr[AW-1:6], 6'b0}`. The first matching condition applies:
  - Out of range (`line < MEM_BASE` or `line >= MEM_LIMIT`): `dram_data <= 0`, set `oob_err`, go to RESP.
  - Buffer valid, `line == buf_tag`, and `buf_flush`=0: `dram_data <= buf_line`, increment `hit_count` (saturating at 16'hFFFF), go to RESP.
  - Otherwise: set `mem_rd_addr <= line`, `mem_rd_req <= 1`, go to ISSUE.
- **ISSUE:** hold `mem_rd_req` high. When `mem_rd_ready`=1, drop it and go to COLLECT with beat counter = 0.
- **COLLECT:** each `mem_rd_valid` writes beat i into `dram_data[64i+63:64i]`. At i=7: set `buf_tag <= line`, `buf_line <=` the assembled line, `buf_valid <= 1`, go to RESP.
- **RESP:** `dram_valid`=1 for exactly one cycle, then go to DONE.
- **DONE:** one cycle in which `dram_req` is ignored (the walker drops it this cycle), then go to IDLE.
- `buf_flush` clears `buf_valid` in any state. If it coincides with the final beat, the buffer fill wins. If it coincides with an IDLE lookup, the lookup is a miss.
- `dram_data` changes only on a response load; the value delivered with `dram_valid` is held until the next load.
- `mem_rd_valid` outside COLLECT: the beat is discarded and `stray_err` is set.
- `dram_req` low in IDLE: no action.

## Timing
- Reset values, asynchronous: state IDLE, `dram_valid` 0, `dram_data` 0, `mem_rd_req` 0, `mem_rd_addr` 0, `oob_err` 0, `stray_err` 0, `hit_count` 0, `buf_valid` 0, beat counter 0.
- Reset mid-burst: the burst is abandoned and no response is sent. The memory side is reset by the same `rst`.
- Hit or OOB: request seen at edge t, `dram_valid` high in cycle t+1. The next request is accepted at edge t+3 at the earliest.
- Miss: request at edge t, `mem_rd_req` high from cycle t+1. With ready at t+1 and back-to-back beats from t+2, the last beat is at t+9 and `dram_valid` is high at t+10.
- Back-pressure: `mem_rd_req` and `mem_rd_addr` stay stable while ready is low. Gaps between beats are allowed.
- Throughput: at most one outstanding burst; no request pipelining.

## Structure
- Package `node_fetch_pkg`: `LINE_BITS` = 512, `LINE_BYTES` = 64, `BEATS_PER_LINE` = 8, the state enum, and the line-align function.
- Sub-module `beat_line_assembler`: beat counter plus 512-bit shift/placement register. Inputs are `mem_rd_valid`, `mem_rd_data`, and a clear; outputs are the line and a `last` pulse.
- The top level holds the FSM, the line buffer, the window check, and the counters.

## Test plan
- Miss at `dram_addr` 32'h1000, memory beats 64'h0..64'h7 with ready immediate → `mem_rd_addr` = 32'h1000; `dram_valid` in cycle t+10; `dram_data[127:64]` = 64'h1.
- Repeat fetch of 32'h1023 → hit on the same line; `dram_valid` at t+1; no `mem_rd_req`; `hit_count` = 1.
- `buf_flush` in the same cycle as a request to 32'h1000 → miss; a new burst is issued.
- `dram_addr` = 32'h0 and `dram_addr` = 32'h0100_0000 → `dram_data` = 0, `valid` at t+1, `oob_err` = 1 and stays set.
- `mem_rd_ready` low for 5 cycles plus 2-cycle beat gaps → address held stable; line correct; exactly one `dram_valid` pulse; `dram_req` ignored in DONE.
- `rst` asserted after beat 3 → all outputs 0; a subsequent request to 32'h1000 is a miss; a stray beat in IDLE sets `stray_err`.

Source files
------------

// File: rtl/node_fetch_pkg.sv
// Shared constants, FSM state type and line-alignment helper for the node-fetch responder.
package node_fetch_pkg;

  localparam int unsigned LINE_BITS      = 512;
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned OFFSET_BITS    = 6;
  localparam int unsigned MAX_ADDR_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COLLECT,
    ST_RESP,
    ST_DONE
  } state_e;

  // Clears the byte offset within a 64-byte line.
  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr);
    return {addr[MAX_ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/node_fetch_responder_beat_line_assembler.sv
// Places in-order read beats into a 512-bit line; flags the beat that completes the line.
module beat_line_assembler
  import node_fetch_pkg::*;
#(
  parameter int unsigned BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [BEAT_BITS-1:0] i_data,
  output logic [LINE_BITS-1:0] o_line_c,
  output logic                 o_last_c
);

  localparam int unsigned CNT_W = $clog2(BEATS_PER_LINE);

  logic [CNT_W-1:0]     r_cnt;
  logic [LINE_BITS-1:0] r_line;
  logic [LINE_BITS-1:0] w_line;

  // Current partial line with the incoming beat merged in, so the last beat is visible immediately.
  always_comb begin
    w_line = r_line;
    if (i_valid) begin
      w_line[int'(r_cnt) * BEAT_BITS +: BEAT_BITS] = i_data;
    end
  end

  assign o_line_c = w_line;
  assign o_last_c = i_valid && (r_cnt == CNT_W'(BEATS_PER_LINE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
    end else if (i_valid) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_line <= w_line;
    end
  end

endmodule

// File: rtl/node_fetch_responder.sv
// Memory-side responder returning one 512-bit tree node per walker request,
// with a one-line buffer and an address window check.
module node_fetch_responder
  import node_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          BEAT_BITS  = 64,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE  = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT = 32'h0100_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_req,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [LINE_BITS-1:0]  dram_data,
  output logic                  dram_valid,
  input  logic                  buf_flush,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic [BEAT_BITS-1:0]  mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  oob_err,
  output logic                  stray_err,
  output logic [15:0]           hit_count
);

  state_e                r_state;
  logic [LINE_BITS-1:0]  r_dram_data;
  logic                  r_dram_valid;
  logic                  r_mem_rd_req;
  logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
  logic                  r_oob_err;
  logic                  r_stray_err;
  logic [15:0]           r_hit_count;
  logic                  r_buf_valid;
  logic [ADDR_WIDTH-1:0] r_buf_tag;
  logic [LINE_BITS-1:0]  r_buf_line;

  logic [ADDR_WIDTH-1:0] w_line;
  logic                  w_oob;
  logic                  w_hit;
  logic                  w_beat_valid;
  logic                  w_asm_clear;
  logic [LINE_BITS-1:0]  w_asm_line;
  logic                  w_asm_last;

  assign w_line       = ADDR_WIDTH'(line_align(MAX_ADDR_W'(dram_addr)));
  assign w_oob        = (w_line < MEM_BASE) || (w_line >= MEM_LIMIT);
  // A flush in the lookup cycle forces a miss.
  assign w_hit        = r_buf_valid && (w_line == r_buf_tag) && !buf_flush;
  assign w_beat_valid = mem_rd_valid && (r_state == ST_COLLECT);
  assign w_asm_clear  = (r_state != ST_COLLECT);

  beat_line_assembler #(
    .BEAT_BITS (BEAT_BITS)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_asm_clear),
    .i_valid  (w_beat_valid),
    .i_data   (mem_rd_data),
    .o_line_c (w_asm_line),
    .o_last_c (w_asm_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dram_data   <= '0;
      r_dram_valid  <= 1'b0;
      r_mem_rd_req  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_oob_err     <= 1'b0;
      r_stray_err   <= 1'b0;
      r_hit_count   <= '0;
      r_buf_valid   <= 1'b0;
      r_buf_tag     <= '0;
      r_buf_line    <= '0;
    end else begin
      r_dram_valid <= 1'b0;
      if (buf_flush) begin
        r_buf_valid <= 1'b0;
      end
      if (mem_rd_valid && (r_state != ST_COLLECT)) begin
        r_stray_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (dram_req) begin
            if (w_oob) begin
              r_dram_data  <= '0;
              r_oob_err    <= 1'b1;
              r_dram_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else if (w_hit) begin
              r_dram_data  <= r_buf_line;
              r_dram_valid <= 1'b1;
              if (r_hit_count != 16'hFFFF) begin
                r_hit_count <= r_hit_count + 16'd1;
              end
              r_state      <= ST_RESP;
            end else begin
              r_mem_rd_addr <= w_line;
              r_mem_rd_req  <= 1'b1;
              r_state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_rd_ready) begin
            r_mem_rd_req <= 1'b0;
            r_state      <= ST_COLLECT;
          end
        end
        // The fill is written after the flush clear above, so a coincident fill wins.
        ST_COLLECT: begin
          if (w_asm_last) begin
            r_dram_data  <= w_asm_line;
            r_buf_tag    <= r_mem_rd_addr;
            r_buf_line   <= w_asm_line;
            r_buf_valid  <= 1'b1;
            r_dram_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dram_data   = r_dram_data;
  assign dram_valid  = r_dram_valid;
  assign mem_rd_req  = r_mem_rd_req;
  assign mem_rd_addr = r_mem_rd_addr;
  assign oob_err     = r_oob_err;
  assign stray_err   = r_stray_err;
  assign hit_count   = r_hit_count;

endmodule
